// File: rtl/axis_slip_encoder_if.sv
// axis_slip_encoder_if -- 8-bit AXI4-Stream byte channel (tdata/tvalid/tready/tlast).
// Modports:
//   master : drives tdata, tvalid, tlast; samples tready
//   slave  : samples tdata, tvalid, tlast; drives tready
interface axis_slip_encoder_if;
  logic [7:0] tdata;
  logic       tvalid;
  logic       tready;
  logic       tlast;

  modport master (output tdata, output tvalid, output tlast, input tready);
  modport slave  (input tdata, input tvalid, input tlast, output tready);
endinterface

// File: rtl/axis_slip_encoder.sv
// axis_slip_encoder -- turns a tlast-framed 8-bit AXI4-Stream into a SLIP
// (RFC 1055) byte stream. In-band END/ESC bytes are escaped, and every packet
// is closed by an END byte, which is marked with m_axis.tlast=1.
//
// Ports:
//   clk     : single clock, all logic on posedge
//   arstn   : asynchronous active-low reset
//   s_axis  : packet input (slave modport), one byte per beat
//   m_axis  : encoded output (master modport), single register stage
//
// Build option:
//   SLIP_START_END_EN : when defined, each packet is also preceded by an END
//                       byte, so the stream is framed END ... END.
//
// FSM states:
//   state   | meaning
//   ST_DATA | accepting input bytes
//   ST_ESC2 | second byte of an escape sequence is pending
//   ST_END  | terminating END byte is pending
module axis_slip_encoder #(
  parameter logic [7:0] END_CHAR = 8'hC0,
  parameter logic [7:0] ESC_CHAR = 8'hDB,
  parameter logic [7:0] ESC_END  = 8'hDC,
  parameter logic [7:0] ESC_ESC  = 8'hDD
) (
  input  logic                       clk,
  input  logic                       arstn,
  axis_slip_encoder_if.slave         s_axis,
  axis_slip_encoder_if.master        m_axis
);

  typedef enum logic [1:0] {
    ST_DATA = 2'd0,
    ST_ESC2 = 2'd1,
    ST_END  = 2'd2
  } state_t;

  state_t     state, state_nxt;
  logic [7:0] pend_byte;
  logic       pend_last;
  logic [7:0] out_data;
  logic       out_valid;
  logic       out_last;

  logic       free;
  logic       accept;
  logic       is_special;
  logic       sop_block;
  logic       load;
  logic [7:0] load_data;
  logic       load_last;

  // The output register can take a new byte when empty or being drained.
  assign free       = !out_valid || m_axis.tready;
  assign is_special = (s_axis.tdata == END_CHAR) || (s_axis.tdata == ESC_CHAR);

`ifdef SLIP_START_END_EN
  logic sop;
  logic sop_set;
  logic sop_clr;

  // sop marks that the next packet still needs its leading END.
  always_ff @(posedge clk or negedge arstn) begin
    if (!arstn)       sop <= 1'b1;
    else if (sop_set) sop <= 1'b1;
    else if (sop_clr) sop <= 1'b0;
  end

  assign sop_block = sop;
`else
  assign sop_block = 1'b0;
`endif

  // Gated by arstn so nothing is accepted while reset is held.
  assign s_axis.tready = arstn && (state == ST_DATA) && free && !sop_block;
  assign accept        = s_axis.tvalid && s_axis.tready;

  // State register
  always_ff @(posedge clk or negedge arstn) begin
    if (!arstn) state <= ST_DATA;
    else        state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      ST_DATA: begin
        if (accept) begin
          if (is_special)         state_nxt = ST_ESC2;
          else if (s_axis.tlast)  state_nxt = ST_END;
        end
      end
      ST_ESC2: if (free) state_nxt = pend_last ? ST_END : ST_DATA;
      ST_END:  if (free) state_nxt = ST_DATA;
      default: state_nxt = ST_DATA;
    endcase
  end

  // Output logic: what, if anything, goes into the output register this cycle
  always_comb begin
    load      = 1'b0;
    load_data = 8'h00;
    load_last = 1'b0;
`ifdef SLIP_START_END_EN
    sop_set   = 1'b0;
    sop_clr   = 1'b0;
`endif
    case (state)
      ST_DATA: begin
`ifdef SLIP_START_END_EN
        // Leading END only once a packet is actually waiting, so idle gaps
        // do not emit extra delimiters. tready is low here, so no accept.
        if (sop && s_axis.tvalid && free) begin
          load      = 1'b1;
          load_data = END_CHAR;
          sop_clr   = 1'b1;
        end
`endif
        if (accept) begin
          load      = 1'b1;
          load_data = is_special ? ESC_CHAR : s_axis.tdata;
        end
      end
      ST_ESC2: begin
        if (free) begin
          load      = 1'b1;
          load_data = pend_byte;
        end
      end
      ST_END: begin
        if (free) begin
          load      = 1'b1;
          load_data = END_CHAR;
          load_last = 1'b1;
`ifdef SLIP_START_END_EN
          sop_set   = 1'b1;
`endif
        end
      end
      default: ;
    endcase
  end

  // Second escape byte and whether it closes the packet
  always_ff @(posedge clk or negedge arstn) begin
    if (!arstn) begin
      pend_byte <= 8'h00;
      pend_last <= 1'b0;
    end else if (accept && is_special) begin
      pend_byte <= (s_axis.tdata == END_CHAR) ? ESC_END : ESC_ESC;
      pend_last <= s_axis.tlast;
    end
  end

  // Output register: data/last only change on a load, so they hold while stalled.
  always_ff @(posedge clk or negedge arstn) begin
    if (!arstn) begin
      out_valid <= 1'b0;
      out_data  <= 8'h00;
      out_last  <= 1'b0;
    end else if (load) begin
      out_valid <= 1'b1;
      out_data  <= load_data;
      out_last  <= load_last;
    end else if (free) begin
      out_valid <= 1'b0;
    end
  end

  assign m_axis.tdata  = out_data;
  assign m_axis.tvalid = out_valid;
  assign m_axis.tlast  = out_last;

endmodule

// File: tb/tb_axis_slip_encoder.sv
// tb_axis_slip_encoder -- directed self-checking bench for axis_slip_encoder.
// Output beats are captured as {tlast, tdata} and compared against
// hand-written expected streams.
module tb_axis_slip_encoder;

  logic clk = 1'b0;
  logic arstn;

  axis_slip_encoder_if s_if ();
  axis_slip_encoder_if m_if ();

  axis_slip_encoder dut (
    .clk    (clk),
    .arstn  (arstn),
    .s_axis (s_if),
    .m_axis (m_if)
  );

  always #5 clk = ~clk;

`ifdef SLIP_START_END_EN
  localparam int SW = 1;
`else
  localparam int SW = 0;
`endif

  int pass_cnt  = 0;
  int total_cnt = 0;

  logic [8:0] in_q[$];
  logic [8:0] exp_q[$];
  logic [8:0] out_q[$];
  int         out_cyc[$];
  int         waits[$];
  bit         bp_en = 1'b0;

  int         cyc       = 0;
  int         stab_err  = 0;
  int         stall_cnt = 0;
  bit         prev_stall = 1'b0;
  logic [7:0] prev_data = 8'h00;
  logic       prev_last = 1'b0;

  // Output monitor: sampled on negedge, a beat with valid&&ready here is
  // transferred at the following posedge.
  always @(negedge clk) begin
    cyc++;
    if (!arstn) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall && (m_if.tvalid !== 1'b1 || m_if.tdata !== prev_data ||
                         m_if.tlast !== prev_last))
        stab_err++;
      if (m_if.tvalid === 1'b1 && m_if.tready === 1'b1) begin
        out_q.push_back({m_if.tlast, m_if.tdata});
        out_cyc.push_back(cyc);
      end
      if (m_if.tvalid === 1'b1 && m_if.tready !== 1'b1) stall_cnt++;
      prev_stall = (m_if.tvalid === 1'b1) && (m_if.tready !== 1'b1);
      prev_data  = m_if.tdata;
      prev_last  = m_if.tlast;
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic step();
    @(posedge clk);
    #1;
    if (bp_en) m_if.tready = 1'($urandom_range(0, 1));
  endtask

  // Drive every entry of in_q; records per-byte stall counts in waits.
  task automatic send();
    waits.delete();
    for (int i = 0; i < in_q.size(); i++) begin
      int w   = 0;
      bit got = 1'b0;
      s_if.tvalid = 1'b1;
      s_if.tdata  = in_q[i][7:0];
      s_if.tlast  = in_q[i][8];
      while (!got && w < 200) begin
        @(negedge clk);
        got = (s_if.tready === 1'b1);
        step();
        if (!got) w++;
      end
      if (!got) begin
        total_cnt++;
        $display("FAIL send_timeout got=%0d exp=<200 byte=%0d", w, i);
      end
      waits.push_back(w);
    end
    s_if.tvalid = 1'b0;
    s_if.tlast  = 1'b0;
    s_if.tdata  = 8'h00;
  endtask

  task automatic drain(input int target);
    int k = 0;
    while (out_q.size() < target && k < 1000) begin
      step();
      k++;
    end
    if (out_q.size() < target) begin
      total_cnt++;
      $display("FAIL drain_timeout got=%0d exp=%0d", out_q.size(), target);
    end
    bp_en       = 1'b0;
    m_if.tready = 1'b1;
    step();
    step();
  endtask

  task automatic count_ready_low(output int lows);
    lows = 0;
    for (int k = 0; k < 50; k++) begin
      @(negedge clk);
      if (s_if.tready === 1'b1) break;
      lows++;
      step();
    end
  endtask

  task automatic test_reset();
    arstn       = 1'b0;
    m_if.tready = 1'b1;
    s_if.tvalid = 1'b1;
    s_if.tdata  = 8'hAA;
    s_if.tlast  = 1'b1;
    @(posedge clk);
    @(posedge clk);
    #1;
    if (m_if.tvalid !== 1'b0) begin total_cnt++; $display("FAIL rst_tvalid got=%b exp=0", m_if.tvalid); end
    else begin pass_cnt++; total_cnt++; end
    if (m_if.tdata !== 8'h00) begin total_cnt++; $display("FAIL rst_tdata got=%h exp=00", m_if.tdata); end
    else begin pass_cnt++; total_cnt++; end
    if (m_if.tlast !== 1'b0) begin total_cnt++; $display("FAIL rst_tlast got=%b exp=0", m_if.tlast); end
    else begin pass_cnt++; total_cnt++; end
    if (s_if.tready !== 1'b0) begin total_cnt++; $display("FAIL rst_s_tready got=%b exp=0", s_if.tready); end
    else begin pass_cnt++; total_cnt++; end
    s_if.tvalid = 1'b0;
    s_if.tlast  = 1'b0;
    s_if.tdata  = 8'h00;
    arstn       = 1'b1;
    step();
    step();
  endtask

  task automatic test_basic();
    int base;
    int n;
    int lows;
    base = out_q.size();
    exp_q.delete();
`ifdef SLIP_START_END_EN
    exp_q.push_back(9'h0C0);
`endif
    exp_q.push_back(9'h001);
    exp_q.push_back(9'h002);
    exp_q.push_back(9'h003);
    exp_q.push_back(9'h1C0);
    in_q = '{9'h001, 9'h002, 9'h103};
    send();
`ifndef SLIP_START_END_EN
    count_ready_low(lows);
    if (lows !== 1) begin total_cnt++; $display("FAIL basic_end_ready_low got=%0d exp=1", lows); end
    else begin pass_cnt++; total_cnt++; end
`endif
    drain(base + exp_q.size());
    n = out_q.size() - base;
    if (n !== exp_q.size()) begin total_cnt++; $display("FAIL basic_count got=%0d exp=%0d", n, exp_q.size()); end
    else begin pass_cnt++; total_cnt++; end
    for (int k = 0; k < exp_q.size() && k < n; k++) begin
      if (out_q[base+k] !== exp_q[k]) begin
        total_cnt++;
        $display("FAIL basic_byte%0d got=%h exp=%h", k, out_q[base+k], exp_q[k]);
      end else begin pass_cnt++; total_cnt++; end
    end
    if (n > 0 && (out_cyc[base+n-1] - out_cyc[base]) !== n - 1) begin
      total_cnt++;
      $display("FAIL basic_consecutive got=%0d exp=%0d", out_cyc[base+n-1] - out_cyc[base], n - 1);
    end else begin pass_cnt++; total_cnt++; end
    if (waits[0] !== SW || waits[1] !== 0 || waits[2] !== 0) begin
      total_cnt++;
      $display("FAIL basic_waits got=%0d,%0d,%0d exp=%0d,0,0", waits[0], waits[1], waits[2], SW);
    end else begin pass_cnt++; total_cnt++; end
  endtask

  task automatic test_escape();
    int base;
    int n;
    int lows;
    base = out_q.size();
    exp_q.delete();
`ifdef SLIP_START_END_EN
    exp_q.push_back(9'h0C0);
`endif
    exp_q.push_back(9'h0DB);
    exp_q.push_back(9'h0DC);
    exp_q.push_back(9'h0DB);
    exp_q.push_back(9'h0DD);
    exp_q.push_back(9'h1C0);
    in_q = '{9'h0C0, 9'h1DB};
    send();
`ifndef SLIP_START_END_EN
    count_ready_low(lows);
    if (lows !== 2) begin total_cnt++; $display("FAIL esc_tail_ready_low got=%0d exp=2", lows); end
    else begin pass_cnt++; total_cnt++; end
`endif
    drain(base + exp_q.size());
    n = out_q.size() - base;
    if (n !== exp_q.size()) begin total_cnt++; $display("FAIL esc_count got=%0d exp=%0d", n, exp_q.size()); end
    else begin pass_cnt++; total_cnt++; end
    for (int k = 0; k < exp_q.size() && k < n; k++) begin
      if (out_q[base+k] !== exp_q[k]) begin
        total_cnt++;
        $display("FAIL esc_byte%0d got=%h exp=%h", k, out_q[base+k], exp_q[k]);
      end else begin pass_cnt++; total_cnt++; end
    end
    if (waits[0] !== SW || waits[1] !== 1) begin
      total_cnt++;
      $display("FAIL esc_waits got=%0d,%0d exp=%0d,1", waits[0], waits[1], SW);
    end else begin pass_cnt++; total_cnt++; end
  endtask

  task automatic test_back_to_back();
    int base;
    int n;
    int lows;
    base = out_q.size();
    exp_q.delete();
`ifdef SLIP_START_END_EN
    exp_q.push_back(9'h0C0);
`endif
    exp_q.push_back(9'h0DB);
    exp_q.push_back(9'h0DD);
    exp_q.push_back(9'h1C0);
`ifdef SLIP_START_END_EN
    exp_q.push_back(9'h0C0);
`endif
    exp_q.push_back(9'h055);
    exp_q.push_back(9'h1C0);
    in_q = '{9'h1DB, 9'h155};
    send();
`ifndef SLIP_START_END_EN
    count_ready_low(lows);
    if (lows !== 1) begin total_cnt++; $display("FAIL b2b_tail_ready_low got=%0d exp=1", lows); end
    else begin pass_cnt++; total_cnt++; end
`endif
    drain(base + exp_q.size());
    n = out_q.size() - base;
    if (n !== exp_q.size()) begin total_cnt++; $display("FAIL b2b_count got=%0d exp=%0d", n, exp_q.size()); end
    else begin pass_cnt++; total_cnt++; end
    for (int k = 0; k < exp_q.size() && k < n; k++) begin
      if (out_q[base+k] !== exp_q[k]) begin
        total_cnt++;
        $display("FAIL b2b_byte%0d got=%h exp=%h", k, out_q[base+k], exp_q[k]);
      end else begin pass_cnt++; total_cnt++; end
    end
    if (waits[0] !== SW || waits[1] !== 2 + SW) begin
      total_cnt++;
      $display("FAIL b2b_waits got=%0d,%0d exp=%0d,%0d", waits[0], waits[1], SW, 2 + SW);
    end else begin pass_cnt++; total_cnt++; end
  endtask

  task automatic test_backpressure();
    int         base;
    int         n;
    int         se0;
    int         st0;
    int         dec_err;
    int         di;
    bit         esc;
    logic [7:0] b;
    logic [7:0] d;
    base = out_q.size();
    se0  = stab_err;
    st0  = stall_cnt;
    in_q.delete();
    exp_q.delete();
`ifdef SLIP_START_END_EN
    exp_q.push_back(9'h0C0);
`endif
    for (int i = 0; i < 64; i++) begin
      if (i % 8 == 3)      b = 8'hC0;
      else if (i % 8 == 6) b = 8'hDB;
      else                 b = 8'(i + 1);
      in_q.push_back({(i == 63), b});
      if (b == 8'hC0) begin
        exp_q.push_back(9'h0DB);
        exp_q.push_back(9'h0DC);
      end else if (b == 8'hDB) begin
        exp_q.push_back(9'h0DB);
        exp_q.push_back(9'h0DD);
      end else begin
        exp_q.push_back({1'b0, b});
      end
    end
    exp_q.push_back(9'h1C0);
    bp_en = 1'b1;
    send();
    drain(base + exp_q.size());
    n = out_q.size() - base;
    if (n !== 81 + SW) begin total_cnt++; $display("FAIL bp_count got=%0d exp=%0d", n, 81 + SW); end
    else begin pass_cnt++; total_cnt++; end
    for (int k = 0; k < exp_q.size() && k < n; k++) begin
      if (out_q[base+k] !== exp_q[k]) begin
        total_cnt++;
        $display("FAIL bp_byte%0d got=%h exp=%h", k, out_q[base+k], exp_q[k]);
      end else begin pass_cnt++; total_cnt++; end
    end
    if (stab_err !== se0) begin total_cnt++; $display("FAIL bp_stable got=%0d exp=%0d", stab_err, se0); end
    else begin pass_cnt++; total_cnt++; end
    if (stall_cnt <= st0) begin total_cnt++; $display("FAIL bp_stalls_seen got=%0d exp=>%0d", stall_cnt, st0); end
    else begin pass_cnt++; total_cnt++; end
    // Decode the captured SLIP stream and compare with the input payload.
    dec_err = 0;
    di      = 0;
    esc     = 1'b0;
    for (int k = base; k < out_q.size(); k++) begin
      d = out_q[k][7:0];
      if (esc) begin
        esc = 1'b0;
        d   = (d == 8'hDC) ? 8'hC0 : (d == 8'hDD) ? 8'hDB : 8'h00;
        if (di >= 64 || d !== in_q[di][7:0]) dec_err++;
        di++;
      end else if (d == 8'hDB) begin
        esc = 1'b1;
      end else if (d != 8'hC0) begin
        if (di >= 64 || d !== in_q[di][7:0]) dec_err++;
        di++;
      end
    end
    if (dec_err !== 0 || di !== 64) begin
      total_cnt++;
      $display("FAIL bp_decode got=%0d_bytes_%0d_errs exp=64_bytes_0_errs", di, dec_err);
    end else begin pass_cnt++; total_cnt++; end
    if (m_if.tvalid !== 1'b0) begin total_cnt++; $display("FAIL bp_idle_tvalid got=%b exp=0", m_if.tvalid); end
    else begin pass_cnt++; total_cnt++; end
  endtask

  task automatic test_reset_mid();
    int base;
    int n;
    m_if.tready = 1'b1;
    in_q = '{9'h0C0};
    send();
    if (s_if.tready !== 1'b0 || m_if.tvalid !== 1'b1 || m_if.tdata !== 8'hDB) begin
      total_cnt++;
      $display("FAIL mid_in_esc2 got=%b%b_%h exp=01_db", s_if.tready, m_if.tvalid, m_if.tdata);
    end else begin pass_cnt++; total_cnt++; end
    arstn = 1'b0;
    #1;
    if (m_if.tvalid !== 1'b0) begin total_cnt++; $display("FAIL mid_rst_tvalid got=%b exp=0", m_if.tvalid); end
    else begin pass_cnt++; total_cnt++; end
    if (s_if.tready !== 1'b0) begin total_cnt++; $display("FAIL mid_rst_s_tready got=%b exp=0", s_if.tready); end
    else begin pass_cnt++; total_cnt++; end
    step();
    if (s_if.tready !== 1'b0) begin total_cnt++; $display("FAIL mid_rst_hold_ready got=%b exp=0", s_if.tready); end
    else begin pass_cnt++; total_cnt++; end
    arstn = 1'b1;
    step();
    base = out_q.size();
    exp_q.delete();
`ifdef SLIP_START_END_EN
    exp_q.push_back(9'h0C0);
`endif
    exp_q.push_back(9'h07E);
    exp_q.push_back(9'h1C0);
    in_q = '{9'h17E};
    send();
    drain(base + exp_q.size());
    n = out_q.size() - base;
    if (n !== exp_q.size()) begin total_cnt++; $display("FAIL mid_count got=%0d exp=%0d", n, exp_q.size()); end
    else begin pass_cnt++; total_cnt++; end
    for (int k = 0; k < exp_q.size() && k < n; k++) begin
      if (out_q[base+k] !== exp_q[k]) begin
        total_cnt++;
        $display("FAIL mid_byte%0d got=%h exp=%h", k, out_q[base+k], exp_q[k]);
      end else begin pass_cnt++; total_cnt++; end
    end
  endtask

  task automatic test_framing();
    int base;
    int n;
    base = out_q.size();
    exp_q.delete();
`ifdef SLIP_START_END_EN
    exp_q = '{9'h0C0, 9'h0AA, 9'h1C0, 9'h0C0, 9'h0DB, 9'h0DC, 9'h1C0};
`else
    exp_q = '{9'h0AA, 9'h1C0, 9'h0DB, 9'h0DC, 9'h1C0};
`endif
    in_q = '{9'h1AA, 9'h1C0};
    send();
    drain(base + exp_q.size());
    n = out_q.size() - base;
    if (n !== exp_q.size()) begin total_cnt++; $display("FAIL frame_count got=%0d exp=%0d", n, exp_q.size()); end
    else begin pass_cnt++; total_cnt++; end
    for (int k = 0; k < exp_q.size() && k < n; k++) begin
      if (out_q[base+k] !== exp_q[k]) begin
        total_cnt++;
        $display("FAIL frame_byte%0d got=%h exp=%h", k, out_q[base+k], exp_q[k]);
      end else begin pass_cnt++; total_cnt++; end
    end
  endtask

  initial begin
    s_if.tvalid = 1'b0;
    s_if.tdata  = 8'h00;
    s_if.tlast  = 1'b0;
    m_if.tready = 1'b1;
    test_reset();
    test_basic();
    test_escape();
    test_back_to_back();
    test_backpressure();
    test_reset_mid();
    test_framing();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
